// File: rtl/rmt_pkg.sv
// Shared RMT pipeline definitions: default key/PHV widths,
// the ternary table entry layout and the key-valid marker bit.
package rmt_pkg;

    localparam int RMT_PHV_LEN = 4*8*64 + 256;
    localparam int RMT_KEY_LEN = 4*8*8 + 1;

    // Bit 0 of every extracted key is a constant 1 marker.
    localparam int KEY_VLD_BIT = 0;

    typedef struct packed {
        logic                   vld;
        logic [RMT_KEY_LEN-1:0] key;
        logic [RMT_KEY_LEN-1:0] mask;
    } tbl_entry_t;

endpackage

// File: rtl/prio_enc_lsb.sv
// Lowest-set-bit priority encoder.
// vec_i: request vector; hit_o: any bit set; idx_o: lowest set index (0 if none).
module prio_enc_lsb #(
    parameter int N    = 16,
    parameter int IDX_W = 4
) (
    input  logic [N-1:0]     vec_i,
    output logic             hit_o,
    output logic [IDX_W-1:0] idx_o
);

    // Scan from the top down so the lowest set bit is the last to assign.
    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                hit_o = 1'b1;
                idx_o = i[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/key_match_lookup.sv
// RMT match stage: ternary lookup of the masked key, 2-cycle pipeline.
// Ports: PHV/key in with valid, cfg table write, PHV/hit/index out, ready_in/out.
module key_match_lookup
    import rmt_pkg::*;
#(
    parameter int STAGE_ID    = 0,
    parameter int PHV_LEN     = RMT_PHV_LEN,
    parameter int KEY_LEN     = RMT_KEY_LEN,
    parameter int NUM_ENTRIES = 16,
    parameter int IDX_W       = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [PHV_LEN-1:0] phv_in,
    input  logic               phv_valid_in,
    input  logic [KEY_LEN-1:0] key_in,
    input  logic               key_valid_in,
    output logic               ready_out,
    input  logic               cfg_wr_en,
    input  logic [IDX_W-1:0]   cfg_wr_idx,
    input  logic [KEY_LEN-1:0] cfg_wr_key,
    input  logic [KEY_LEN-1:0] cfg_wr_mask,
    input  logic               cfg_wr_vld,
    output logic [PHV_LEN-1:0] phv_out,
    output logic               phv_valid_out,
    output logic               hit_out,
    output logic [IDX_W-1:0]   action_idx_out,
    output logic               action_valid_out,
    input  logic               ready_in
);

    tbl_entry_t tbl_q [NUM_ENTRIES];

    logic [NUM_ENTRIES-1:0] match_d;
    logic [NUM_ENTRIES-1:0] match_q;
    logic [PHV_LEN-1:0]     phv1_q;
    logic                   v1_q;

    logic                   hit_d;
    logic [IDX_W-1:0]       idx_d;

    logic [PHV_LEN-1:0]     phv2_q;
    logic                   v2_q;
    logic                   hit_q;
    logic [IDX_W-1:0]       idx_q;

    logic                   accept;

    assign ready_out = ready_in;

    // A key without a PHV is dropped; a PHV without a key still flows.
    assign accept = phv_valid_in & ready_in;

    // Table reads here see the pre-write contents on a cfg write edge.
    always_comb begin
        match_d = '0;
        for (int e = 0; e < NUM_ENTRIES; e++) begin
            match_d[e] = tbl_q[e].vld
                & ~|((key_in ^ tbl_q[e].key) & ~tbl_q[e].mask);
        end
        if (!key_valid_in) begin
            match_d = '0;
        end
    end

    // Only valid bits need a reset; key/mask are qualified by vld.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int e = 0; e < NUM_ENTRIES; e++) begin
                tbl_q[e].vld <= 1'b0;
            end
        end else if (cfg_wr_en) begin
            tbl_q[cfg_wr_idx].vld  <= cfg_wr_vld;
            tbl_q[cfg_wr_idx].key  <= cfg_wr_key;
            tbl_q[cfg_wr_idx].mask <= cfg_wr_mask;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            match_q <= '0;
            phv1_q  <= '0;
            v1_q    <= 1'b0;
        end else if (ready_in) begin
            v1_q <= accept;
            if (accept) begin
                match_q <= match_d;
                phv1_q  <= phv_in;
            end
        end
    end

    prio_enc_lsb #(
        .N     (NUM_ENTRIES),
        .IDX_W (IDX_W)
    ) u_prio (
        .vec_i (match_q),
        .hit_o (hit_d),
        .idx_o (idx_d)
    );

    // Data fields load only with a packet so they hold across bubbles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phv2_q <= '0;
            v2_q   <= 1'b0;
            hit_q  <= 1'b0;
            idx_q  <= '0;
        end else if (ready_in) begin
            v2_q <= v1_q;
            if (v1_q) begin
                phv2_q <= phv1_q;
                hit_q  <= hit_d;
                idx_q  <= idx_d;
            end
        end
    end

    assign phv_out          = phv2_q;
    assign phv_valid_out    = v2_q;
    assign action_valid_out = v2_q;
    assign hit_out          = hit_q;
    assign action_idx_out   = idx_q;

endmodule
